rtc_bus_ctrl: RTL and testbench

Bus-cycle engine for the multiplexed address/data RTC port, one level below the clock/timer read and write sequencers. It sequences one complete RTC transaction (address write, then data write or data read) per request. Handshaking uses single-cycle step strobes: `dir`, `dat`, `dat2`, `cambio_estado`, `cambio_estado2`. The upstream sequencer supplies address and write data on one shared byte, `dato_dir`. This block drives CS/RD/WR/A-D and the bus, and returns the read byte on `dato_l`.

---
 rtl/rtc_bus_ctrl.sv | 133 +++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle engine for the multiplexed address/data RTC port: one address write
// followed by one data write or data read per request, each bus phase T_PHASE cycles long.
module rtc_bus_ctrl #(
   parameter int T_PHASE = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       tr,
   input  logic [7:0] dato_dir,
   input  logic [7:0] bus_in,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       ad_n,
   output logic       dir,
   output logic       dat,
   output logic       dat2,
   output logic       cambio_estado,
   output logic       cambio_estado2,
   output logic [7:0] dato_l,
   output logic       busy
);

   localparam logic [4:0] IDLE    = 5'd0;
   localparam logic [4:0] REQ_A   = 5'd1;
   localparam logic [4:0] LATCH_A = 5'd2;
   localparam logic [4:0] A_SET   = 5'd3;
   localparam logic [4:0] A_STB   = 5'd4;
   localparam logic [4:0] A_HLD   = 5'd5;
   localparam logic [4:0] REQ_D   = 5'd6;
   localparam logic [4:0] DECIDE  = 5'd7;
   localparam logic [4:0] W_SET   = 5'd8;
   localparam logic [4:0] W_STB   = 5'd9;
   localparam logic [4:0] W_HLD   = 5'd10;
   localparam logic [4:0] DONE_W  = 5'd11;
   localparam logic [4:0] R_SET   = 5'd12;
   localparam logic [4:0] R_STB   = 5'd13;
   localparam logic [4:0] R_HLD   = 5'd14;
   localparam logic [4:0] STRB    = 5'd15;
   localparam logic [4:0] DONE_R  = 5'd16;
   localparam logic [4:0] REC     = 5'd17;

   localparam logic [7:0] PH_LAST = 8'(T_PHASE - 1);

   logic [4:0] state;
   logic [4:0] state_d;
   logic [7:0] cnt;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       ph_end;

   // Line levels for a state, packed as {cs_n, rd_n, wr_n, ad_n, bus_oe, dir, dat, dat2, ce, ce2, busy}.
   function automatic logic [10:0] decode(input logic [4:0] s);
      logic c, r, w, a, o;
      c = 1'b1;
      r = 1'b1;
      w = 1'b1;
      a = 1'b1;
      o = 1'b0;
      case (s)
         A_SET, A_HLD: begin c = 1'b0; a = 1'b0; o = 1'b1; end
         A_STB:        begin c = 1'b0; a = 1'b0; o = 1'b1; w = 1'b0; end
         W_SET, W_HLD: begin c = 1'b0; o = 1'b1; end
         W_STB:        begin c = 1'b0; o = 1'b1; w = 1'b0; end
         R_SET, R_HLD: begin c = 1'b0; end
         R_STB:        begin c = 1'b0; r = 1'b0; end
         default:      begin end
      endcase
      return {c, r, w, a, o, (s == REQ_A), (s == REQ_D), (s == STRB),
              (s == DONE_W), (s == DONE_R), (s != IDLE)};
   endfunction

   assign ph_end = (cnt == 8'd0);

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (en) state_d = REQ_A;
         REQ_A:   state_d = LATCH_A;
         LATCH_A: state_d = A_SET;
         A_SET:   if (ph_end) state_d = A_STB;
         A_STB:   if (ph_end) state_d = A_HLD;
         A_HLD:   if (ph_end) state_d = REQ_D;
         REQ_D:   state_d = DECIDE;
         DECIDE:  state_d = tr ? W_SET : R_SET;
         W_SET:   if (ph_end) state_d = W_STB;
         W_STB:   if (ph_end) state_d = W_HLD;
         W_HLD:   if (ph_end) state_d = DONE_W;
         DONE_W:  state_d = REC;
         R_SET:   if (ph_end) state_d = R_STB;
         R_STB:   if (ph_end) state_d = R_HLD;
         R_HLD:   if (ph_end) state_d = STRB;
         STRB:    state_d = DONE_R;
         DONE_R:  state_d = REC;
         REC:     if (ph_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lines are registered from the next state so the RTC strobes never glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         dato_l <= 8'd0;
         {cs_n, rd_n, wr_n, ad_n, bus_oe, dir, dat, dat2,
          cambio_estado, cambio_estado2, busy} <= decode(IDLE);
      end else begin
         state <= state_d;
         if (state_d != state)
            cnt <= PH_LAST;
         else if (!ph_end)
            cnt <= cnt - 8'd1;
         if (state == R_STB && ph_end)
            dato_l <= bus_in;
         {cs_n, rd_n, wr_n, ad_n, bus_oe, dir, dat, dat2,
          cambio_estado, cambio_estado2, busy} <= decode(state_d);
      end
   end

   always_ff @(posedge clk) begin
      if (state == LATCH_A)
         addr <= dato_dir;
      if (state == DECIDE && tr)
         wdata <= dato_dir;
   end

   assign bus_out = bus_oe ? (ad_n ? wdata : addr) : 8'h00;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: two instances (T_PHASE 8 and 1) sharing clock and reset.
module tb_rtc_bus_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, tr;
   logic [7:0] dato_dir, bus_in, bus_out, dato_l;
   logic       bus_oe, cs_n, rd_n, wr_n, ad_n, dir, dat, dat2, cambio_estado, cambio_estado2, busy;

   logic       q_en, q_tr;
   logic [7:0] q_dato_dir, q_bus_in, q_bus_out, q_dato_l;
   logic       q_bus_oe, q_cs_n, q_rd_n, q_wr_n, q_ad_n, q_dir, q_dat, q_dat2, q_ce, q_ce2, q_busy;

   int checks = 0;
   int errors = 0;

   int wseg, rseg, bad_wr, bad_rd, cs_fall, dir_cyc, dat_cyc;
   int ce_n, ce_cyc, ce2_n, ce2_cyc, dat2_n, dat2_cyc, busy_last, rec_cnt;
   int wr_first[0:1], wr_last[0:1], rd_first, rd_last;
   logic [7:0] dl_at_dat2;
   logic timeout;

   always #5 clk = ~clk;

   rtc_bus_ctrl #(.T_PHASE(8)) dut (
      .clk(clk), .reset(reset), .en(en), .tr(tr), .dato_dir(dato_dir), .bus_in(bus_in),
      .bus_out(bus_out), .bus_oe(bus_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n),
      .dir(dir), .dat(dat), .dat2(dat2), .cambio_estado(cambio_estado),
      .cambio_estado2(cambio_estado2), .dato_l(dato_l), .busy(busy)
   );

   rtc_bus_ctrl #(.T_PHASE(1)) dut1 (
      .clk(clk), .reset(reset), .en(q_en), .tr(q_tr), .dato_dir(q_dato_dir), .bus_in(q_bus_in),
      .bus_out(q_bus_out), .bus_oe(q_bus_oe), .cs_n(q_cs_n), .rd_n(q_rd_n), .wr_n(q_wr_n),
      .ad_n(q_ad_n), .dir(q_dir), .dat(q_dat), .dat2(q_dat2), .cambio_estado(q_ce),
      .cambio_estado2(q_ce2), .dato_l(q_dato_l), .busy(q_busy)
   );

   // Runs one transaction on the T=8 instance from an IDLE cycle (cycle 0) and records events.
   task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rb, input logic hold_en);
      int c;
      logic pw, pr, after_done, ended;
      wseg = 0; rseg = 0; bad_wr = 0; bad_rd = 0; cs_fall = -1; dir_cyc = -1; dat_cyc = -1;
      ce_n = 0; ce_cyc = -1; ce2_n = 0; ce2_cyc = -1; dat2_n = 0; dat2_cyc = -1;
      busy_last = -1; rec_cnt = 0; rd_first = -1; rd_last = -1; dl_at_dat2 = 8'h00;
      wr_first[0] = -1; wr_first[1] = -1; wr_last[0] = -1; wr_last[1] = -1;
      bus_in = rb; en = 1'b1; tr = ~w; dato_dir = 8'hEE;
      pw = 1'b1; pr = 1'b1; after_done = 1'b0; ended = 1'b0; c = 0;
      while (!ended && c < 300) begin
         @(negedge clk);
         c++;
         if (dir === 1'b1) begin dir_cyc = c; dato_dir = a; if (!hold_en) en = 1'b0; end
         if (dat === 1'b1) begin dat_cyc = c; dato_dir = d; tr = w; end
         if (cs_n === 1'b0 && cs_fall < 0) cs_fall = c;
         if (wr_n === 1'b0) begin
            if (pw) begin wseg++; if (wseg <= 2) wr_first[wseg-1] = c; end
            if (wseg <= 2) wr_last[wseg-1] = c;
            if (wseg == 1 && (bus_out !== a || ad_n !== 1'b0 || bus_oe !== 1'b1 || cs_n !== 1'b0)) bad_wr++;
            if (wseg == 2 && (bus_out !== d || ad_n !== 1'b1 || bus_oe !== 1'b1 || cs_n !== 1'b0)) bad_wr++;
         end
         if (rd_n === 1'b0) begin
            if (pr) begin rseg++; rd_first = c; end
            rd_last = c;
            if (bus_oe !== 1'b0 || cs_n !== 1'b0 || ad_n !== 1'b1) bad_rd++;
         end
         pw = wr_n; pr = rd_n;
         if (after_done && busy === 1'b1 && cs_n === 1'b1 && rd_n === 1'b1 && wr_n === 1'b1 && bus_oe === 1'b0)
            rec_cnt++;
         if (cambio_estado === 1'b1) begin ce_n++; ce_cyc = c; after_done = 1'b1; end
         if (cambio_estado2 === 1'b1) begin ce2_n++; ce2_cyc = c; after_done = 1'b1; end
         if (dat2 === 1'b1) begin dat2_n++; dat2_cyc = c; dl_at_dat2 = dato_l; end
         if (busy !== 1'b1) begin ended = 1'b1; busy_last = c - 1; end
      end
      timeout = !ended;
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b0; en = 1'b1; tr = 1'b0; dato_dir = 8'h00; bus_in = 8'h5C;
      repeat (3) @(negedge clk);
      checks++; if ({cs_n, rd_n, wr_n, ad_n} !== 4'hF) begin errors++; $display("FAIL rst_strobes got %b exp 1111", {cs_n, rd_n, wr_n, ad_n}); end
      checks++; if (bus_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_oe_busy got %b%b exp 00", bus_oe, busy); end
      checks++; if ({dir, dat, dat2, cambio_estado, cambio_estado2} !== 5'b0) begin errors++; $display("FAIL rst_pulses got %b exp 00000", {dir, dat, dat2, cambio_estado, cambio_estado2}); end
      checks++; if (bus_out !== 8'h00 || dato_l !== 8'h00) begin errors++; $display("FAIL rst_bytes got %h/%h exp 00/00", bus_out, dato_l); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (dir !== 1'b1) begin errors++; $display("FAIL rst_dir_first got %b exp 1", dir); end
      en = 1'b0;
      @(negedge clk);
      checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rst_dir_second got %b exp 0", dir); end
      n = 0;
      while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_drain busy got %b exp 0", busy); end
   endtask

   task automatic test_write();
      run_txn(1'b1, 8'hF1, 8'h00, 8'hA5, 1'b0);
      checks++; if (timeout) begin errors++; $display("FAIL wr_timeout got 1 exp 0"); end
      checks++; if (dir_cyc != 1 || cs_fall != 3) begin errors++; $display("FAIL wr_dir_cs got %0d/%0d exp 1/3", dir_cyc, cs_fall); end
      checks++; if (wr_first[0] != 11 || wr_last[0] != 18) begin errors++; $display("FAIL wr_addr_strobe got %0d-%0d exp 11-18", wr_first[0], wr_last[0]); end
      checks++; if (dat_cyc != 27) begin errors++; $display("FAIL wr_dat got %0d exp 27", dat_cyc); end
      checks++; if (wr_first[1] != 37 || wr_last[1] != 44 || wseg != 2) begin errors++; $display("FAIL wr_data_strobe got %0d-%0d n%0d exp 37-44 n2", wr_first[1], wr_last[1], wseg); end
      checks++; if (bad_wr != 0) begin errors++; $display("FAIL wr_bus_value got %0d bad cycles exp 0", bad_wr); end
      checks++; if (ce_n != 1 || ce_cyc != 53) begin errors++; $display("FAIL wr_done got n%0d c%0d exp n1 c53", ce_n, ce_cyc); end
      checks++; if (ce2_n != 0 || dat2_n != 0 || rseg != 0) begin errors++; $display("FAIL wr_no_read got %0d/%0d/%0d exp 0/0/0", ce2_n, dat2_n, rseg); end
      checks++; if (busy_last != 61) begin errors++; $display("FAIL wr_busy_end got %0d exp 61", busy_last); end
      checks++; if (rec_cnt != 8) begin errors++; $display("FAIL wr_rec got %0d exp 8", rec_cnt); end
   endtask

   task automatic test_read();
      run_txn(1'b0, 8'h21, 8'h99, 8'h37, 1'b0);
      checks++; if (timeout) begin errors++; $display("FAIL rd_timeout got 1 exp 0"); end
      checks++; if (rd_first != 37 || rd_last != 44 || rseg != 1) begin errors++; $display("FAIL rd_strobe got %0d-%0d n%0d exp 37-44 n1", rd_first, rd_last, rseg); end
      checks++; if (bad_rd != 0) begin errors++; $display("FAIL rd_oe_during_rd got %0d exp 0", bad_rd); end
      checks++; if (wseg != 1 || bad_wr != 0) begin errors++; $display("FAIL rd_addr_only got n%0d bad%0d exp n1 bad0", wseg, bad_wr); end
      checks++; if (dat2_n != 1 || dat2_cyc != 53 || dl_at_dat2 !== 8'h37) begin errors++; $display("FAIL rd_dat2 got n%0d c%0d d%h exp n1 c53 d37", dat2_n, dat2_cyc, dl_at_dat2); end
      checks++; if (ce2_n != 1 || ce2_cyc != 54 || ce_n != 0) begin errors++; $display("FAIL rd_done got n%0d c%0d w%0d exp n1 c54 w0", ce2_n, ce2_cyc, ce_n); end
      checks++; if (busy_last != 62) begin errors++; $display("FAIL rd_busy_end got %0d exp 62", busy_last); end
      bus_in = 8'hC3;
      repeat (5) @(negedge clk);
      checks++; if (dato_l !== 8'h37) begin errors++; $display("FAIL rd_hold got %h exp 37", dato_l); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rb;
      for (int i = 0; i < 6; i++) begin
         rb = 8'h50 + 8'(i * 13);
         run_txn(1'b0, 8'h21 + 8'(i), 8'h00, rb, (i < 5));
         checks++; if (timeout || dat2_n != 1 || dl_at_dat2 !== rb) begin errors++; $display("FAIL b2b_%0d got t%0b n%0d d%h exp t0 n1 d%h", i, timeout, dat2_n, dl_at_dat2, rb); end
         checks++; if (rec_cnt < 8 || ce2_n != 1) begin errors++; $display("FAIL b2b_rec_%0d got rec%0d ce2 %0d exp rec>=8 ce2 1", i, rec_cnt, ce2_n); end
      end
   endtask

   task automatic test_abort();
      int n, bad;
      en = 1'b1; tr = 1'b1; dato_dir = 8'h3C; n = 0;
      while (wr_n !== 1'b0 && n < 60) begin
         @(negedge clk); n++;
         if (dir === 1'b1) en = 1'b0;
      end
      checks++; if (wr_n !== 1'b0 || cs_n !== 1'b0) begin errors++; $display("FAIL abort_reach_stb got wr%b cs%b exp 0/0", wr_n, cs_n); end
      #2 reset = 1'b0;
      #1;
      checks++; if (wr_n !== 1'b1 || cs_n !== 1'b1 || bus_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_async got wr%b cs%b oe%b busy%b exp 1 1 0 0", wr_n, cs_n, bus_oe, busy); end
      checks++; if (dato_l !== 8'h00) begin errors++; $display("FAIL abort_dato_l got %h exp 00", dato_l); end
      @(negedge clk);
      reset = 1'b1; en = 1'b0; bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (cambio_estado !== 1'b0 || cambio_estado2 !== 1'b0 || dat2 !== 1'b0 || dir !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL abort_idle got %0d active cycles exp 0", bad); end
   endtask

   task automatic test_min_phase();
      int c, lo, run, run_max, ce_c, bl, bad, pulse_bad;
      q_en = 1'b1; q_tr = 1'b0; q_dato_dir = 8'hEE; q_bus_in = 8'h00;
      lo = 0; run = 0; run_max = 0; ce_c = -1; bl = -1; bad = 0; pulse_bad = 0;
      for (c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (q_dir === 1'b1) begin q_dato_dir = 8'hF2; q_en = 1'b0; if (c != 1) pulse_bad++; end
         if (q_dat === 1'b1) begin q_dato_dir = 8'h5A; q_tr = 1'b1; if (c != 6) pulse_bad++; end
         if (q_wr_n === 1'b0) begin
            lo++; run++;
            if (run > run_max) run_max = run;
            if (c == 4 && (q_bus_out !== 8'hF2 || q_ad_n !== 1'b0)) bad++;
            if (c == 9 && (q_bus_out !== 8'h5A || q_ad_n !== 1'b1)) bad++;
            if (c != 4 && c != 9) bad++;
         end else run = 0;
         if (q_ce === 1'b1) ce_c = c;
         if (q_ce2 === 1'b1 || q_rd_n === 1'b0) bad++;
         if (q_busy === 1'b1) bl = c;
      end
      checks++; if (ce_c != 11) begin errors++; $display("FAIL t1_done got %0d exp 11", ce_c); end
      checks++; if (lo != 2 || run_max != 1) begin errors++; $display("FAIL t1_strobe_len got lo%0d max%0d exp lo2 max1", lo, run_max); end
      checks++; if (bad != 0 || pulse_bad != 0) begin errors++; $display("FAIL t1_bus got %0d/%0d exp 0/0", bad, pulse_bad); end
      checks++; if (bl != 12) begin errors++; $display("FAIL t1_busy_end got %0d exp 12", bl); end
   endtask

   initial begin
      q_en = 1'b0; q_tr = 1'b0; q_dato_dir = 8'h00; q_bus_in = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_abort();
      test_min_phase();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
